// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The optional divide datapath is enabled by defining MULTDIV_DIV_EN.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

    localparam int unsigned MULTDIV_ITERS = 32;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // Two's-complement magnitude; INT_MIN maps to 0x80000000 read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/multdiv_divstep.sv
// One combinational restoring-division step on unsigned magnitudes.
// Compiled only when MULTDIV_DIV_EN is defined.
`ifdef MULTDIV_DIV_EN
module multdiv_divstep
(
    input  logic [31:0] rem_in,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] shifted;

    // Shift in the next dividend bit and subtract the divisor when it fits.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? 32'(shifted - {1'b0, divisor}) : shifted[31:0];
    end

endmodule
`endif

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply/divide unit with a fixed 32-cycle latency.
// Define MULTDIV_DIV_EN to compile in the divide datapath; without it a divide
// request still runs the full sequence and returns result 0, exception 1.
module multdiv
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    // acc: product accumulator (mult) or partial remainder in [31:0] (div)
    logic [63:0] acc_q, acc_d;
    // mcand: shifted multiplicand (mult) or divisor in [31:0] (div)
    logic [63:0] mcand_q, mcand_d;
    // shreg: multiplier shifting right (mult) or dividend/quotient shifting left (div)
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic        start;
    logic [31:0] mag_a, mag_b;
    logic [63:0] prod_s;

`ifdef MULTDIV_DIV_EN
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rem_next;
    logic        q_bit;

    multdiv_divstep u_divstep (
        .rem_in       (acc_q[31:0]),
        .dividend_bit (shreg_q[31]),
        .divisor      (mcand_q[31:0]),
        .rem_out      (rem_next),
        .q_bit        (q_bit)
    );
`endif

    // Next-state, datapath step and result formation.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        shreg_d  = shreg_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        prod_s   = '0;
`ifdef MULTDIV_DIV_EN
        dz_d     = dz_q;
        ovf_d    = ovf_q;
`endif
        start = ctrl_MULT | ctrl_DIV;
        mag_a = abs32(data_operandA);
        mag_b = abs32(data_operandB);

        if (start) begin
            // A start in any state (re)launches; an aborted op never strobes.
            state_d = RUN;
            op_d    = ctrl_MULT ? OP_MULT : OP_DIV;
            cnt_d   = '0;
            sign_d  = data_operandA[31] ^ data_operandB[31];
            acc_d   = '0;
            if (ctrl_MULT) begin
                mcand_d = {32'd0, mag_a};
                shreg_d = mag_b;
            end else begin
                mcand_d = {32'd0, mag_b};
                shreg_d = mag_a;
            end
`ifdef MULTDIV_DIV_EN
            dz_d  = (data_operandB == '0);
            ovf_d = (data_operandA == INT_MIN) && (data_operandB == '1);
`endif
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    cnt_d = cnt_q + 6'd1;
                    if (op_q == OP_MULT) begin
                        acc_d   = acc_q + (shreg_q[0] ? mcand_q : '0);
                        mcand_d = mcand_q << 1;
                        shreg_d = shreg_q >> 1;
                    end else begin
`ifdef MULTDIV_DIV_EN
                        acc_d   = {32'd0, rem_next};
                        shreg_d = {shreg_q[30:0], q_bit};
`endif
                    end
                    if (cnt_q == 6'(MULTDIV_ITERS - 1)) begin
                        state_d = DONE;
                        rdy_d   = 1'b1;
                        if (op_q == OP_MULT) begin
                            prod_s   = sign_q ? (64'd0 - acc_d) : acc_d;
                            result_d = prod_s[31:0];
                            exc_d    = (prod_s[63:32] != {32{prod_s[31]}});
                        end else begin
`ifdef MULTDIV_DIV_EN
                            if (dz_q) begin
                                result_d = '0;
                                exc_d    = 1'b1;
                            end else begin
                                // INT_MIN / -1 yields magnitude 0x80000000 either way.
                                result_d = sign_q ? (32'd0 - shreg_d) : shreg_d;
                                exc_d    = ovf_q;
                            end
`else
                            result_d = '0;
                            exc_d    = 1'b1;
`endif
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Register all state and outputs; synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            shreg_q  <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            shreg_q  <= shreg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
`ifdef MULTDIV_DIV_EN
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_multdiv;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_assert = 0;
    int n_fail   = 0;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed product, or C-style truncating quotient.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic is_mult,
                         output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else begin
`ifdef MULTDIV_DIV_EN
            if (b == 32'd0) begin
                r = 32'd0;
                e = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = 32'h8000_0000;
                e = 1'b1;
            end else begin
                q = $signed(a) / $signed(b);
                r = q;
                e = 1'b0;
            end
`else
            r = 32'd0;
            e = 1'b1;
`endif
        end
    endtask

    // Called just after a rising edge; the start is sampled at the next edge.
    task automatic issue_start(input logic [31:0] a, input logic [31:0] b,
                               input logic m, input logic d);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp_r,
                               input logic exp_e, input logic chk_width);
        int k;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                k = i;
                break;
            end
        end
        check({tag, "_latency"}, 32'(k), 32'd32);
        check({tag, "_result"}, data_result, exp_r);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_e});
        if (chk_width) begin
            @(posedge clock);
            #1;
            check({tag, "_strobe_width"}, {31'd0, data_resultRDY}, 32'd0);
            check({tag, "_hold"}, data_result, exp_r);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic d);
        logic [31:0] r;
        logic        e;
        model(a, b, m, r, e);
        issue_start(a, b, m, d);
        wait_result(tag, r, e, 1'b1);
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic        ee, rm;
        int          strobes;

        reset         = 1'b1;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed cases from the test plan and boundaries.
        run_op("mul_7xm6", 32'd7, 32'hFFFF_FFFA, 1'b1, 1'b0);
        run_op("mul_ovf", 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        run_op("mul_intmin_x1", 32'h8000_0000, 32'd1, 1'b1, 1'b0);
        run_op("mul_intmin_xm1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        run_op("div_by_zero", 32'd5, 32'd0, 1'b0, 1'b1);
        run_op("div_intmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op("div_10_2", 32'd10, 32'd2, 1'b0, 1'b1);
        run_op("mul_10x2", 32'd10, 32'd2, 1'b1, 1'b0);
        run_op("both_6_3", 32'd6, 32'd3, 1'b1, 1'b1);

        // Abort: second start 10 cycles in replaces the first op.
        issue_start(32'd3, 32'd4, 1'b1, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        issue_start(32'd5, 32'd5, 1'b1, 1'b0);
        wait_result("abort_5x5", 32'd25, 1'b0, 1'b1);

        // Reset in the middle of a divide: outputs clear, no strobe follows.
        issue_start(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset_result", data_result, 32'd0);
        check("midreset_exc", {31'd0, data_exception}, 32'd0);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) strobes++;
        end
        check("midreset_no_strobe", 32'(strobes), 32'd0);

        // Back-to-back: next start sampled in the DONE cycle.
        model(32'hFFFF_FFFD, 32'd9, 1'b1, er, ee);
        issue_start(32'hFFFF_FFFD, 32'd9, 1'b1, 1'b0);
        wait_result("b2b_first", er, ee, 1'b0);
        model(32'd1000, 32'hFFFF_FFF6, 1'b0, er, ee);
        issue_start(32'd1000, 32'hFFFF_FFF6, 1'b0, 1'b1);
        wait_result("b2b_second", er, ee, 1'b1);

        // Random operands and ops.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(0, 1) ? 32'($urandom_range(1, 20)) : 32'd0 - 32'($urandom_range(1, 20));
                2: rb = 32'd0;
                default: rb = 32'hFFFF_FFFF;
            endcase
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            rm = 1'($urandom_range(0, 1));
            run_op(rm ? "rand_mul" : "rand_div", ra, rb, rm, ~rm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv.md
# multdiv

Iterative signed 32-bit multiply/divide unit, the multi-cycle counterpart to the single-cycle ALU in the processor datapath. The execute stage issues a one-cycle start pulse with two operands. The unit runs a fixed 32-iteration shift-add or restoring-divide sequence and returns a registered result with a one-cycle ready strobe. The processor stalls on `data_resultRDY`. All arithmetic is two's complement, matching ALU operand conventions.

## Interface
- No parameters. Iteration count is fixed at 32 (package constant).
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `data_operandA` input 32: signed multiplicand or dividend, sampled only on a start edge.
- `data_operandB` input 32: signed multiplier or divisor, sampled only on a start edge.
- `ctrl_MULT` input 1: start-multiply pulse.
- `ctrl_DIV` input 1: start-divide pulse.
- `data_result` output 32: signed product (low 32 bits) or quotient; registered.
- `data_exception` output 1: overflow, divide-by-zero or disabled-op flag; registered.
- `data_resultRDY` output 1: one-cycle result-valid strobe.

## Operation
- Reset values:
  - FSM = IDLE.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
  - Counter and internal registers = 0.
- States and transitions:
  - IDLE → RUN on a start edge.
  - RUN → DONE after iteration 32.
  - DONE → IDLE after one cycle.
  - DONE → RUN if a start is sampled in DONE.
- On a start edge:
  - Latch operand magnitudes and the result sign (sign A XOR sign B).
  - Latch the op.
  - Clear the counter.
- Start priority: `ctrl_MULT` beats `ctrl_DIV` when both are high.
- A start during RUN aborts the current op and restarts with the new operands; no ready strobe is issued for the aborted op.
- Multiply:
  - 32-step radix-2 shift-add on 32-bit magnitudes into a 64-bit accumulator.
  - Negate the accumulator at the end if the result sign is 1.
  - `data_result` = low 32 bits.
  - `data_exception` = 1 when the 64-bit signed product ≠ sign-extension of its low 32 bits.
- Divide:
  - 32-step restoring division on magnitudes; quotient truncates toward zero; remainder discarded.
  - Quotient is negated if the result sign is 1.
  - Divisor 0 → `data_result` = 0, `data_exception` = 1.
  - 0x80000000 / −1 → `data_result` = 0x80000000, `data_exception` = 1.
- `data_result` and `data_exception` update only on entry to DONE. They hold until the next DONE or reset.
- Reset mid-operation drops the op: no strobe, outputs return to reset values.

## Timing
- A start is sampled at edge E0; iterations run at edges E1..E32.
- Result registers load at E32; `data_resultRDY` is high for exactly one cycle, E32 to E33.
- Latency is a fixed 32 cycles for every case, including divide-by-zero and overflow.
- Back-to-back: a start sampled at E33 (the DONE cycle) is accepted; the next strobe follows 32 cycles later.
- Start pulses arriving while `data_resultRDY` is high are legal.

## Configuration
- `MULTDIV_DIV_EN` defined:
  - Divide datapath compiled in; behaviour as above.
- `MULTDIV_DIV_EN` undefined:
  - Divider logic removed.
  - `ctrl_DIV` still runs the 32-cycle sequence, then returns `data_result` = 0 and `data_exception` = 1.
  - Multiply behaviour is unchanged.

## Structure
- Package `multdiv_pkg` holds:
  - FSM state enum (IDLE, RUN, DONE).
  - Op enum (OP_MULT, OP_DIV).
  - `MULTDIV_ITERS` = 32.
  - `INT_MIN` constant 32'h80000000.
- One sub-module, `multdiv_divstep`: combinational single restoring-division step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Compiled only under `MULTDIV_DIV_EN`.

## Test plan
- MULT 7 × −6 → strobe 32 cycles after start; result 0xFFFFFFD6 (−42); exception 0.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1. DIV −7 / 2 → result 0xFFFFFFFD (−3), exception 0.
- DIV 5 / 0 → result 0, exception 1. DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 1.
- MULT 3 × 4 started, then at cycle 10 a new MULT 5 × 5 → single strobe 32 cycles after the second start; result 25.
- Reset asserted at cycle 15 of a divide → outputs 0, no strobe. Simultaneous `ctrl_MULT` + `ctrl_DIV` with 6, 3 → result 18.
- Build without `MULTDIV_DIV_EN`: DIV 10 / 2 → result 0, exception 1 after 32 cycles. MULT 10 × 2 → 20.
